encode_scheduler: RTL and testbench
===================================

// Module: encode_scheduler
// PURPOSE
// Round-robin scheduler sharing one encode_packet instance among NUM_REQ local requesters.
// Picks one pending request and drives its payload/destination to the encoder.
// Sequences the encoder handshake: grant pulse, then valid/ready, then wait for encode_done.
// Acks the requester on completion; a watchdog aborts hung transfers.
// PARAMETERS
// NUM_REQ        4     number of requesters (>=2)
// DATA_WIDTH     1024  payload width per requester
// ADDR_WIDTH     10    destination router address width
// TIMEOUT_CYCLES 64    max cycles from entering REQ_ENC to seeing encode_done
// PORTS
// clk                   in   1                     clock
// rst                   in   1                     synchronous reset, active-high
// sched_en              in   1                     0 = start no new transfers (current one completes)
// req_i                 in   NUM_REQ               per-requester request level
// req_data_i            in   NUM_REQ*DATA_WIDTH    payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
// req_dst_i             in   NUM_REQ*ADDR_WIDTH    destinations, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
// req_ack_o             out  NUM_REQ               one-hot 1-cycle pulse: transfer done
// data_arbiter_send     out  DATA_WIDTH            payload to encoder (registered)
// arbiter_gnt           out  1                     1-cycle grant pulse to encoder
// ctrl_encode_valid_o   out  1                     start request to encoder
// ctrl_encode_ready_i   in   1                     encoder ready
// router_dst_addr_send  out  ADDR_WIDTH            destination to encoder (registered)
// encode_done           in   1                     encoder completion pulse
// busy_o                out  1                     1 whenever state != IDLE
// timeout_err_o         out  1                     1-cycle pulse on watchdog abort
// BEHAVIOUR
// - Reset: state=IDLE, rr pointer=0 (req 0 highest priority); all outputs 0.
// - All outputs registered; the design is a single clk domain.
// - States: IDLE, GRANT, REQ_ENC, WAIT_DONE, ACK.
// - IDLE: if sched_en && |req_i, select the first set req at/after pointer, wrapping NUM_REQ-1 -> 0.
//   Capture the idx, data and dst into output regs -> GRANT. Otherwise stay in IDLE.
// - GRANT (1 cycle): arbiter_gnt=1 -> REQ_ENC.
// - REQ_ENC: ctrl_encode_valid_o=1, held until a clock edge with ctrl_encode_ready_i=1.
//   On that edge -> WAIT_DONE, and valid drops in the next cycle.
// - WAIT_DONE: on encode_done=1 -> ACK.
// - ACK (1 cycle): req_ack_o[idx]=1; pointer = idx+1 mod NUM_REQ -> IDLE.
// - data_arbiter_send/router_dst_addr_send hold constant from GRANT until the next IDLE capture.
//   This covers the encoder's late data sample after the grant.
// - Requester holds req_i until its ack; data/dst need only be valid on the selection edge.
// - Latency: req seen in IDLE at edge 0 -> gnt in cycle 1 -> valid from cycle 2.
//   Ack is asserted in the cycle after the edge that samples encode_done.
// - Watchdog: counter (width clog2(TIMEOUT_CYCLES+1)) clears on entering REQ_ENC.
//   It increments each cycle in REQ_ENC and WAIT_DONE.
//   At TIMEOUT_CYCLES-1 with no done/handshake: timeout_err_o pulse, no ack, pointer = idx+1, -> IDLE.
//   If done and timeout occur on the same edge, done wins.
// - encode_done outside WAIT_DONE is ignored. sched_en is only sampled in IDLE.
// - A req dropped mid-transfer does not abort it; the ack is still issued.
// - Reset mid-operation: immediate return to reset values; no ack and no error pulse.
// TESTING
// - req_i=4'b0100, ready=1, done 20 cyc after handshake -> gnt cyc1, valid cyc2 only.
//   Dst/data of req2 on outputs; req_ack_o=4'b0100 once.
// - req_i=4'b1111 held, each acked then dropped -> grant order 0,1,2,3; pointer wraps to 0.
// - req0 and req2 held continuously -> grants alternate 0,2,0,2.
// - ready low for 5 cyc in REQ_ENC -> valid held 5+1 cyc, arbiter_gnt still exactly 1 cyc.
// - encode_done never asserted -> timeout_err_o pulse 64 cyc after REQ_ENC entry.
//   No ack; next req granted.
// - rst=1 during WAIT_DONE -> next cycle all outputs 0, busy_o=0; a pending req1 is granted first after reset.

Source files
------------

// File: rtl/encode_scheduler.sv
// Round-robin scheduler sharing one encoder among NUM_REQ requesters: grant pulse, valid/ready, wait for done, ack.
// Grant one cycle after a request is seen in IDLE; valid is held until ready; a watchdog aborts hung transfers.
module encode_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sched_en,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_i,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [DATA_WIDTH-1:0]         data_arbiter_send,
  output logic                          arbiter_gnt,
  output logic                          ctrl_encode_valid_o,
  input  logic                          ctrl_encode_ready_i,
  output logic [ADDR_WIDTH-1:0]         router_dst_addr_send,
  input  logic                          encode_done,
  output logic                          busy_o,
  output logic                          timeout_err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    REQ_ENC,
    WAIT_DONE,
    ACK
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] pick;
  logic [CW-1:0] wd_cnt;
  logic          start;
  logic          timeout;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Scan from the far end back so the closest set request at/after ptr wins.
  always_comb begin
    pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[wrap_add(ptr, i)]) pick = wrap_add(ptr, i);
    end
  end

  assign start   = (state == IDLE) && sched_en && (|req_i);
  // Handshake/done take precedence over an expiring watchdog on the same edge.
  assign timeout = (wd_cnt >= CNT_LAST) &&
                   (((state == REQ_ENC) && !ctrl_encode_ready_i) ||
                    ((state == WAIT_DONE) && !encode_done));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = GRANT;
      GRANT:     state_n = REQ_ENC;
      REQ_ENC: begin
        if (ctrl_encode_ready_i) state_n = WAIT_DONE;
        else if (timeout)        state_n = IDLE;
      end
      WAIT_DONE: begin
        if (encode_done)  state_n = ACK;
        else if (timeout) state_n = IDLE;
      end
      ACK:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr                  <= '0;
      idx                  <= '0;
      wd_cnt               <= '0;
      req_ack_o            <= '0;
      data_arbiter_send    <= '0;
      router_dst_addr_send <= '0;
      arbiter_gnt          <= 1'b0;
      ctrl_encode_valid_o  <= 1'b0;
      busy_o               <= 1'b0;
      timeout_err_o        <= 1'b0;
    end else begin
      arbiter_gnt         <= (state_n == GRANT);
      ctrl_encode_valid_o <= (state_n == REQ_ENC);
      busy_o              <= (state_n != IDLE);
      timeout_err_o       <= timeout;
      req_ack_o           <= '0;
      if (state_n == ACK) req_ack_o[idx] <= 1'b1;

      if (start) begin
        idx                  <= pick;
        data_arbiter_send    <= req_data_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
        router_dst_addr_send <= req_dst_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
      end

      if ((state == ACK) || timeout) ptr <= wrap_add(idx, 1);

      if (state == GRANT)
        wd_cnt <= '0;
      else if ((state == REQ_ENC) || (state == WAIT_DONE))
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_encode_scheduler.sv
// Scoreboard bench for encode_scheduler: a round-robin reference model predicts the transfer sequence,
// a responder plays the encoder, and a monitor checks every grant, ack and timeout against the queue.
module tb_encode_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DW      = 1024;
  localparam int AW      = 10;
  localparam int TO      = 64;

  logic                  clk;
  logic                  rst;
  logic                  sched_en;
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*DW-1:0] req_data_i;
  logic [NUM_REQ*AW-1:0] req_dst_i;
  logic [NUM_REQ-1:0]    req_ack_o;
  logic [DW-1:0]         data_arbiter_send;
  logic                  arbiter_gnt;
  logic                  ctrl_encode_valid_o;
  logic                  ctrl_encode_ready_i;
  logic [AW-1:0]         router_dst_addr_send;
  logic                  encode_done;
  logic                  busy_o;
  logic                  timeout_err_o;

  encode_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req_i(req_i),
    .req_data_i(req_data_i), .req_dst_i(req_dst_i), .req_ack_o(req_ack_o),
    .data_arbiter_send(data_arbiter_send), .arbiter_gnt(arbiter_gnt),
    .ctrl_encode_valid_o(ctrl_encode_valid_o), .ctrl_encode_ready_i(ctrl_encode_ready_i),
    .router_dst_addr_send(router_dst_addr_send), .encode_done(encode_done),
    .busy_o(busy_o), .timeout_err_o(timeout_err_o)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic [AW-1:0] dst;
    int            rdy;
    int            dly;
    bit            hang;
  } xfer_t;

  xfer_t         exp_q[$];
  xfer_t         beh_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            done_cyc = -100;
  bit            have_cur = 0;
  int            m_ptr = 0;
  int            m_rem[NUM_REQ];
  int            drv_cnt[NUM_REQ];
  logic [DW-1:0] rq_data[NUM_REQ];
  logic [AW-1:0] rq_dst[NUM_REQ];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: next winner is the first still-pending requester at/after the pointer.
  task automatic plan(input int max_x, input int hang_at, input int rdy_fix, input int dly_fix);
    int t;
    t = 0;
    while (t < max_x) begin
      int    k;
      xfer_t e;
      k = -1;
      for (int j = 0; j < NUM_REQ; j++) begin
        int c;
        c = (m_ptr + j) % NUM_REQ;
        if (k < 0 && m_rem[c] > 0) k = c;
      end
      if (k < 0) break;
      e.idx  = k;
      e.data = rq_data[k];
      e.dst  = rq_dst[k];
      e.rdy  = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
      e.dly  = (dly_fix >= 0) ? dly_fix : int'($urandom_range(0, 8));
      e.hang = (t == hang_at);
      exp_q.push_back(e);
      beh_q.push_back(e);
      m_ptr = (k + 1) % NUM_REQ;
      if (!e.hang) m_rem[k]--;
      t++;
    end
  endtask

  task automatic setup_reqs(input logic [NUM_REQ-1:0] mask, input int n);
    for (int k = 0; k < NUM_REQ; k++) begin
      rq_data[k] = rand_data();
      rq_dst[k]  = AW'($urandom);
      m_rem[k]   = mask[k] ? n : 0;
      drv_cnt[k] = mask[k] ? n : 0;
      req_data_i[k*DW +: DW] = rq_data[k];
      req_dst_i[k*AW +: AW]  = rq_dst[k];
    end
  endtask

  // Requesters hold until their n-th ack; run until everything drains.
  task automatic wait_idle(input string name, input int start_cyc);
    int first_gnt;
    bit done;
    first_gnt = -1;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (arbiter_gnt && first_gnt < 0) first_gnt = cyc;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ack_o[k] && drv_cnt[k] > 0) begin
          drv_cnt[k]--;
          if (drv_cnt[k] == 0) req_i[k] = 1'b0;
        end
      end
      if (req_i == '0 && !busy_o && exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain: phase did not complete, %0d transfers still expected", name, exp_q.size());
      req_i = '0;
      repeat (200) @(negedge clk);
      exp_q.delete();
      beh_q.delete();
    end else begin
      chk({name, "_first_gnt_cycle"}, 64'(first_gnt), 64'(start_cyc + 1));
    end
  endtask

  task automatic run_phase(input string name, input logic [NUM_REQ-1:0] mask, input int n,
                           input int hang_at, input int rdy_fix, input int dly_fix);
    setup_reqs(mask, n);
    plan(100, hang_at, rdy_fix, dly_fix);
    req_i = mask;
    wait_idle(name, cyc);
  endtask

  // Encoder stand-in: ready after rdy cycles, done pulse dly cycles after the handshake unless hung.
  initial begin
    xfer_t b;
    ctrl_encode_ready_i = 1'b0;
    encode_done         = 1'b0;
    forever begin
      @(negedge clk);
      if (ctrl_encode_valid_o) begin
        if (beh_q.size() > 0) begin
          b = beh_q.pop_front();
        end else begin
          b.rdy  = 0;
          b.dly  = 0;
          b.hang = 0;
        end
        repeat (b.rdy) @(negedge clk);
        ctrl_encode_ready_i = 1'b1;
        @(negedge clk);
        ctrl_encode_ready_i = 1'b0;
        if (!b.hang) begin
          repeat (b.dly) @(negedge clk);
          encode_done = 1'b1;
          done_cyc    = cyc;
          @(negedge clk);
          encode_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the expected transfer on each grant and checks what follows it.
  initial begin
    xfer_t cur;
    bit    prev_gnt;
    bit    prev_valid;
    int    gnt_cyc;
    int    vrise;
    prev_gnt   = 0;
    prev_valid = 0;
    gnt_cyc    = -100;
    vrise      = -100;
    cur.rdy    = 0;
    forever begin
      @(negedge clk);
      if (arbiter_gnt) begin
        chk("gnt_single_cycle", 64'(prev_gnt), 64'(0));
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: grant seen with no transfer expected (cycle %0d)", cyc);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          chk("gnt_data_equal", 64'(data_arbiter_send == cur.data), 64'(1));
          chk("gnt_data_low", data_arbiter_send[63:0], cur.data[63:0]);
          chk("gnt_dst", 64'(router_dst_addr_send), 64'(cur.dst));
        end
        gnt_cyc = cyc;
      end
      if (ctrl_encode_valid_o && !prev_valid) begin
        chk("gnt_to_valid", 64'(cyc), 64'(gnt_cyc + 1));
        vrise = cyc;
      end
      if (!ctrl_encode_valid_o && prev_valid)
        chk("valid_length", 64'(cyc - vrise), 64'(cur.rdy + 1));
      if (req_ack_o != '0) begin
        if (!have_cur) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: ack %b with no open transfer (cycle %0d)", req_ack_o, cyc);
        end else begin
          chk("ack_onehot", 64'(req_ack_o), 64'(1) << cur.idx);
          chk("ack_not_hung", 64'(cur.hang), 64'(0));
          chk("ack_latency", 64'(cyc), 64'(done_cyc + 1));
          chk("data_held_to_ack", 64'(data_arbiter_send == cur.data), 64'(1));
          chk("busy_in_ack", 64'(busy_o), 64'(1));
        end
        have_cur = 0;
      end
      if (timeout_err_o) begin
        if (!have_cur) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_timeout: timeout with no open transfer (cycle %0d)", cyc);
        end else begin
          chk("timeout_expected", 64'(cur.hang), 64'(1));
          chk("timeout_latency", 64'(cyc - vrise), 64'(TO));
          chk("timeout_no_ack", 64'(req_ack_o), 64'(0));
        end
        have_cur = 0;
      end
      prev_gnt   = arbiter_gnt;
      prev_valid = ctrl_encode_valid_o;
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy_o), 64'(0));
    chk({name, "_gnt"}, 64'(arbiter_gnt), 64'(0));
    chk({name, "_valid"}, 64'(ctrl_encode_valid_o), 64'(0));
    chk({name, "_ack"}, 64'(req_ack_o), 64'(0));
    chk({name, "_timeout"}, 64'(timeout_err_o), 64'(0));
    chk({name, "_dst"}, 64'(router_dst_addr_send), 64'(0));
    chk({name, "_data"}, 64'(data_arbiter_send == '0), 64'(1));
  endtask

  initial begin
    bit seen;
    bit ok;
    bit any_busy;
    rst        = 1'b1;
    sched_en   = 1'b1;
    req_i      = '0;
    req_data_i = '0;
    req_dst_i  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      m_rem[k]   = 0;
      drv_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_phase("all_four", 4'b1111, 1, -1, -1, -1);
    run_phase("single_req2", 4'b0100, 1, -1, 0, 20);
    run_phase("alternate_0_2", 4'b0101, 2, -1, -1, -1);
    run_phase("ready_low5", 4'b0010, 1, -1, 5, 2);
    run_phase("watchdog", 4'b0110, 1, 0, 0, -1);

    // Disabled scheduler must not start anything.
    setup_reqs(4'b0001, 1);
    sched_en = 1'b0;
    req_i    = 4'b0001;
    any_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_o || arbiter_gnt) any_busy = 1;
    end
    chk("sched_en_blocks", 64'(any_busy), 64'(0));
    plan(100, -1, -1, -1);
    sched_en = 1'b1;
    wait_idle("sched_en_resume", cyc);

    // Reset while waiting for done; the pointer returns to 0 so req1 goes before req3.
    setup_reqs(4'b1010, 1);
    plan(1, 0, 0, 0);
    req_i = 4'b1010;
    seen  = 0;
    ok    = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ctrl_encode_valid_o) seen = 1;
      if (seen && !ctrl_encode_valid_o && busy_o) ok = 1;
    end
    chk("rst_reached_wait_done", 64'(ok), 64'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst      = 1'b0;
    have_cur = 0;
    m_ptr    = 0;
    plan(100, -1, -1, -1);
    wait_idle("after_reset", cyc);

    for (int p = 0; p < 6; p++) begin
      logic [NUM_REQ-1:0] mask;
      int                 n;
      int                 hang;
      mask = NUM_REQ'($urandom_range(1, 15));
      n    = int'($urandom_range(1, 3));
      hang = ($urandom_range(0, 3) == 0) ? 0 : -1;
      run_phase("random", mask, n, hang, -1, -1);
    end

    repeat (5) @(negedge clk);
    chk("end_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("end_idle", 64'(busy_o), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
